branch_predictor: RTL

Branch target buffer and direction predictor that steers the IF stage. Each cycle it looks up the current fetch PC and drives `hit`, `taken` and `pred_PC` to the fetch stage. When a branch or jump resolves in EX, it trains its tables, and on a misprediction it raises `flush` with the corrected `redirect_PC`. It also keeps saturating performance counters for resolved control transfers and mispredictions.

---
 rtl/branch_predictor.sv | 112 +++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, misprediction flush and perf counters.
// Define BP_GSHARE_EN to move the counters into a GHR-xored pattern history table.
module branch_predictor #(
    parameter int ENTRIES  = 16,
    parameter int GHR_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_PC,
    output logic        hit,
    output logic        taken,
    output logic [31:0] pred_PC,
    input  logic        ex_valid,
    input  logic [31:0] ex_PC,
    input  logic        ex_is_branch,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_PC,
    output logic        flush,
    output logic [31:0] redirect_PC,
    output logic [31:0] branch_count,
    output logic [31:0] mispred_count
);
    localparam int IDX = $clog2(ENTRIES);
    localparam int TW  = 30 - IDX;

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] jump_q;
    logic [TW-1:0]      tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    // Per-entry counters by default; the pattern history table under gshare.
    logic [1:0]         ctr_q    [ENTRIES];

    logic [IDX-1:0] f_idx, e_idx, f_cidx, e_cidx;
    logic [TW-1:0]  f_tag, e_tag;
    logic           e_hit;
    logic           mispredict;
    logic           unused_pc_bits;

    assign f_idx = fetch_PC[IDX+1:2];
    assign f_tag = fetch_PC[31:IDX+2];
    assign e_idx = ex_PC[IDX+1:2];
    assign e_tag = ex_PC[31:IDX+2];
    assign unused_pc_bits = ^{fetch_PC[1:0], ex_PC[1:0]};

`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0] ghr_q;
    assign f_cidx = f_idx ^ IDX'(ghr_q);
    assign e_cidx = e_idx ^ IDX'(ghr_q);
`else
    logic [GHR_BITS-1:0] ghr_unused;
    assign ghr_unused = '0;
    assign f_cidx = f_idx;
    assign e_cidx = e_idx;
`endif

    assign hit     = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign taken   = hit && (jump_q[f_idx] || ctr_q[f_cidx][1]);
    assign pred_PC = taken ? target_q[f_idx] : fetch_PC + 32'd4;

    assign e_hit      = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    assign mispredict = ex_valid && ((ex_taken != ex_pred_taken) ||
                                     (ex_taken && (ex_pred_PC != ex_target)));

    assign flush       = mispredict && !rst;
    assign redirect_PC = ex_taken ? ex_target : ex_PC + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= '0;
            jump_q        <= '0;
            branch_count  <= '0;
            mispred_count <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'b00;
            end
`ifdef BP_GSHARE_EN
            ghr_q <= '0;
`endif
        end else if (ex_valid) begin
            if (branch_count != 32'hFFFF_FFFF) begin
                branch_count <= branch_count + 32'd1;
            end
            if (mispredict && (mispred_count != 32'hFFFF_FFFF)) begin
                mispred_count <= mispred_count + 32'd1;
            end
            if (e_hit) begin
                if (ex_taken) begin
                    target_q[e_idx] <= ex_target;
                    if (ctr_q[e_cidx] != 2'b11) begin
                        ctr_q[e_cidx] <= ctr_q[e_cidx] + 2'b01;
                    end
                end else if (ctr_q[e_cidx] != 2'b00) begin
                    ctr_q[e_cidx] <= ctr_q[e_cidx] - 2'b01;
                end
            end else if (ex_taken) begin
                // Direct-mapped: a conflicting tag is simply replaced.
                valid_q[e_idx]  <= 1'b1;
                tag_q[e_idx]    <= e_tag;
                target_q[e_idx] <= ex_target;
                jump_q[e_idx]   <= !ex_is_branch;
                ctr_q[e_cidx]   <= ex_is_branch ? 2'b10 : 2'b11;
            end
`ifdef BP_GSHARE_EN
            if (ex_is_branch) begin
                ghr_q <= (ghr_q << 1) | GHR_BITS'(ex_taken);
            end
`endif
        end
    end
endmodule
